// File: rtl/tensor_core_sequencer.sv
// rtl/tensor_core_sequencer.sv - streams two 4x4 byte matrices into an external tensor core and streams the product back out
// Elements arrive and leave in row-major order; idx is shared by the load and drain phases.
module tensor_core_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] core_input1 [4][4],
    output logic [7:0] core_input2 [4][4],
    input  logic [7:0] core_output [4][4],
    output logic       busy
);

    localparam logic [1:0] LOAD_A  = 2'd0;
    localparam logic [1:0] LOAD_B  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    logic [1:0] state;
    logic [3:0] idx;
    logic [7:0] a_reg [4][4];
    logic [7:0] b_reg [4][4];
    logic [7:0] r_reg [4][4];
    logic [1:0] row;
    logic [1:0] col;
    logic       in_fire;
    logic       out_fire;

    assign row       = idx[3:2];
    assign col       = idx[1:0];
    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign out_valid = (state == DRAIN);
    assign busy      = (state == CAPTURE) || (state == DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // R only changes in CAPTURE, so out_data is inherently stable across a stall.
    assign out_data    = (state == DRAIN) ? r_reg[row][col] : 8'h00;
    assign core_input1 = a_reg;
    assign core_input2 = b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
            idx   <= 4'd0;
            a_reg <= '{default: 8'h00};
            b_reg <= '{default: 8'h00};
            r_reg <= '{default: 8'h00};
        end else begin
            case (state)
                LOAD_A: begin
                    if (in_fire) begin
                        a_reg[row][col] <= in_data;
                        idx             <= idx + 4'd1;
                        if (idx == 4'd15) state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (in_fire) begin
                        b_reg[row][col] <= in_data;
                        idx             <= idx + 4'd1;
                        if (idx == 4'd15) state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_reg <= core_output;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (out_fire) begin
                        idx <= idx + 4'd1;
                        if (idx == 4'd15) state <= LOAD_A;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// tb/tb_tensor_core_sequencer.sv - directed bench for tensor_core_sequencer with a behavioural 4x4 mod-256 tensor core
module tb_tensor_core_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] core_input1 [4][4];
    logic [7:0] core_input2 [4][4];
    logic [7:0] core_output [4][4];
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] ma  [16];
    logic [7:0] mb  [16];
    logic [7:0] ma2 [16];
    logic [7:0] mb2 [16];
    logic [7:0] exp1 [16];
    logic [7:0] exp2 [16];

    tensor_core_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .core_input1 (core_input1),
        .core_input2 (core_input2),
        .core_output (core_output),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational core: 8-bit context keeps every sum modulo 256.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                core_output[i][j] = core_input1[i][0] * core_input2[0][j]
                                  + core_input1[i][1] * core_input2[1][j]
                                  + core_input1[i][2] * core_input2[2][j]
                                  + core_input1[i][3] * core_input2[3][j];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void golden(input logic [7:0] a [16], input logic [7:0] b [16],
                                   output logic [7:0] r [16]);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 4; k++) s += int'(a[i*4+k]) * int'(b[k*4+j]);
                r[i*4+j] = s[7:0];
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic push(input logic [7:0] d, input bit gaps);
        int n;
        n = 0;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] a [16], input logic [7:0] b [16], input bit gaps);
        for (int i = 0; i < 16; i++) push(a[i], gaps);
        for (int i = 0; i < 16; i++) push(b[i], gaps);
    endtask

    task automatic drain(input logic [7:0] e [16], input int stall_k);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 16; k++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_data", 32'(out_data), 32'(e[k]));
            chk("drain_in_ready", 32'(in_ready), 32'd0);
            if (k == stall_k) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(e[k]));
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("after_drain_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity times 1..16 returns 1..16; checks the two-cycle latency
        for (int i = 0; i < 16; i++) begin
            ma[i]   = (i % 5 == 0) ? 8'h01 : 8'h00;
            mb[i]   = 8'(i + 1);
            exp1[i] = 8'(i + 1);
        end
        load(ma, mb, 1'b0);
        chk("capture_valid", 32'(out_valid), 32'd0);
        chk("capture_busy", 32'(busy), 32'd1);
        chk("capture_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_data", 32'(out_data), 32'h01);
        drain(exp1, -1);

        // All 0xFF: 4*0xFF*0xFF mod 256 = 0x04
        for (int i = 0; i < 16; i++) begin
            ma[i]   = 8'hFF;
            mb[i]   = 8'hFF;
            exp1[i] = 8'h04;
        end
        load(ma, mb, 1'b0);
        drain(exp1, -1);

        // Random matrices, gappy input, 5-cycle stall mid drain
        for (int i = 0; i < 16; i++) begin
            ma[i] = 8'($urandom);
            mb[i] = 8'($urandom);
        end
        golden(ma, mb, exp1);
        load(ma, mb, 1'b1);
        drain(exp1, 7);

        // Reset after 20 inputs, asserted between clock edges
        for (int i = 0; i < 16; i++) begin
            ma[i] = 8'($urandom) | 8'h01;
            mb[i] = 8'($urandom) | 8'h01;
        end
        for (int i = 0; i < 16; i++) push(ma[i], 1'b0);
        for (int i = 0; i < 4; i++) push(mb[i], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_a", 32'(core_input1[0][0]), 32'd0);
        chk("async_rst_b", 32'(core_input2[0][0]), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ma2[i] = 8'($urandom);
            mb2[i] = 8'($urandom);
        end
        golden(ma2, mb2, exp2);
        load(ma2, mb2, 1'b0);
        drain(exp2, -1);

        // Back-to-back with in_valid held high through capture and drain
        for (int i = 0; i < 16; i++) begin
            ma[i]  = 8'($urandom) & 8'h7F;
            mb[i]  = 8'($urandom);
            ma2[i] = 8'($urandom);
            mb2[i] = 8'($urandom);
        end
        ma2[0] = 8'hAA;
        golden(ma, mb, exp1);
        golden(ma2, mb2, exp2);
        load(ma, mb, 1'b0);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        chk("b2b_capture_in_ready", 32'(in_ready), 32'd0);
        drain(exp1, -1);
        chk("b2b_reopen_in_ready", 32'(in_ready), 32'd1);
        chk("b2b_a00_not_early", 32'(core_input1[0][0]), 32'(ma[0]));
        @(negedge clk);
        chk("b2b_a00_accepted", 32'(core_input1[0][0]), 32'hAA);
        for (int i = 1; i < 16; i++) push(ma2[i], 1'b0);
        for (int i = 0; i < 16; i++) push(mb2[i], 1'b0);
        drain(exp2, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tensor_core_sequencer.md
TENSOR_CORE_SEQUENCER -- requirements
Module: tensor_core_sequencer

Interface
REQ-001 SHALL have no parameters; matrix dimension fixed at 4x4, element width fixed at 8 bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port in_data, input, 8 bits: streamed matrix element.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-006 SHALL have port in_ready, output, 1 bit: sequencer accepts in_data.
REQ-007 SHALL have port out_data, output, 8 bits: streamed result element.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-010 SHALL have port core_input1, output, 8 bits x [4][4]: matrix A to the combinational tensor core.
REQ-011 SHALL have port core_input2, output, 8 bits x [4][4]: matrix B to the tensor core.
REQ-012 SHALL have port core_output, input, 8 bits x [4][4]: product A*B from the tensor core.
REQ-013 SHALL have port busy, output, 1 bit: high in CAPTURE and DRAIN.

Function
REQ-014 SHALL implement FSM states LOAD_A, LOAD_B, CAPTURE, DRAIN, plus a 4-bit element index idx.
REQ-015 SHALL count an input transfer only in a cycle with in_valid=1 and in_ready=1, and an output transfer only with out_valid=1 and out_ready=1.
REQ-016 SHALL drive in_ready=1 exactly in LOAD_A and LOAD_B, and in_ready=0 otherwise.
REQ-017 SHALL on an input transfer in LOAD_A write in_data to A[idx/4][idx%4] (row-major) and increment idx; in LOAD_B, write to B likewise.
REQ-018 SHALL on the transfer at idx=15 wrap idx to 0 and move LOAD_A->LOAD_B or LOAD_B->CAPTURE.
REQ-019 SHALL drive core_input1/core_input2 continuously from the A/B registers; those registers change only on input transfers.
REQ-020 SHALL in CAPTURE (exactly one cycle) register all 16 core_output elements into a result register R, then move to DRAIN.
REQ-021 SHALL in DRAIN drive out_valid=1 and out_data=R[idx/4][idx%4]; on output transfer increment idx; at idx=15 wrap to 0 and move to LOAD_A.
REQ-022 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive out_valid=0 in LOAD_A, LOAD_B and CAPTURE.
REQ-024 SHALL ignore in_valid/in_data outside LOAD states, and ignore out_ready outside DRAIN.
REQ-025 SHALL give latency: last B element accepted at edge N -> R captured at edge N+1 -> out_valid=1 with R[0][0] during the cycle after edge N+1.
REQ-026 SHALL treat all arithmetic as modulo 256 (whatever the core produces is forwarded unmodified; no saturation).
REQ-027 SHALL not clear A, B or R between operations; each operation overwrites all 16 entries before use.
REQ-028 SHALL sustain one input transfer per cycle in LOAD states and one output transfer per cycle in DRAIN with no bubbles.

Reset
REQ-029 SHALL on rst_n=0, immediately and independent of clk, set state=LOAD_A, idx=0, A=B=R=0, out_valid=0, out_data=0, busy=0; in_ready=1 once in LOAD_A.
REQ-030 SHALL on reset mid-operation (any state) abandon the operation; no partial result is emitted after reset release.
REQ-031 SHALL resume normal operation on the first clk edge after rst_n deasserts.

Verification
REQ-032 Identity A (1 on diagonal), B = 0x01..0x10 row-major, out_ready=1 -> out stream 0x01..0x10 in order; out_valid first high 2 cycles after last B.
REQ-033 A and B all 0xFF -> 16 outputs each 0x04 (4*0xFF*0xFF mod 256).
REQ-034 Random A,B, in_valid toggled randomly, out_ready held low 5 cycles mid-drain -> out_data stable during stall; results match mod-256 golden model; no drop or duplicate.
REQ-035 Reset asserted after 20 inputs, then fresh 32 inputs -> outputs reflect only the fresh matrices; out_valid=0 throughout reset.
REQ-036 Two back-to-back operations with in_valid=1 continuously -> in_ready=0 during CAPTURE and DRAIN, second operation's first element accepted only after the 16th output transfer.
